// File: rtl/demux_1to4_if.sv
// Bus bundle for demux_1to4: select/data in, four routed outputs plus error status.
// Pure wiring, no state; the demux drives the outputs one clk after sampling Sel/E.
// No backpressure: every cycle is independent. err_cnt exists only with DEMUX_1TO4_ERRCNT_EN.
interface demux_1to4_if #(
    parameter int DW = 1
);
    logic [1:0]    Sel;
    logic [DW-1:0] E;
    logic [DW-1:0] Out1;
    logic [DW-1:0] Out2;
    logic [DW-1:0] Out3;
    logic [DW-1:0] Out4;
    logic          err;
`ifdef DEMUX_1TO4_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    // Source side: drives select/data, observes routed results.
    modport master (
        output Sel,
        output E,
        input  Out1,
        input  Out2,
        input  Out3,
        input  Out4,
        input  err
`ifdef DEMUX_1TO4_ERRCNT_EN
        , input err_cnt
`endif
    );

    // Demux side: samples select/data, drives routed results.
    modport slave (
        input  Sel,
        input  E,
        output Out1,
        output Out2,
        output Out3,
        output Out4,
        output err
`ifdef DEMUX_1TO4_ERRCNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/demux_1to4.sv
// Registered 1-to-N_OUT demultiplexer: routes E to the output chosen by Sel, flags invalid selects.
// Latency: exactly one clk from Sel/E sampling to Out*/err (and err_cnt).
// No backpressure or handshake; optional saturating err_cnt under macro DEMUX_1TO4_ERRCNT_EN.
module demux_1to4 #(
    parameter int DW    = 1,
    parameter int N_OUT = 4
) (
    input  logic         clk,
    input  logic         rst,
    demux_1to4_if.slave  bus
);
    // Select range compared at 3 bits so N_OUT = 4 makes every 2-bit Sel valid.
    localparam logic [2:0] N_OUT_W = 3'(N_OUT);

    logic                 sel_valid;
    logic [3:0][DW-1:0]   out_q;
    logic [3:0][DW-1:0]   out_drv;
    logic                 err_q;

    assign sel_valid = ({1'b0, bus.Sel} < N_OUT_W);

    // Decode and register: selected port takes E, all others clear; invalid select clears all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sel_valid && (bus.Sel == 2'(i))) begin
                    out_q[i] <= bus.E;
                end else begin
                    out_q[i] <= '0;
                end
            end
            err_q <= ~sel_valid;
        end
    end

    // Ports beyond N_OUT are hard-tied low so they prune away regardless of the register.
    always_comb begin
        out_drv = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < N_OUT) begin
                out_drv[i] = out_q[i];
            end
        end
    end

    assign bus.Out1 = out_drv[0];
    assign bus.Out2 = out_drv[1];
    assign bus.Out3 = out_drv[2];
    assign bus.Out4 = out_drv[3];
    assign bus.err  = err_q;

`ifdef DEMUX_1TO4_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Count invalid-select edges, sticking at 255 rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (!sel_valid && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_demux_1to4.sv
// Directed-vector bench for demux_1to4 across several parameterisations.
// Checks land 1 time unit after the rising edge; inputs change right after the checks.
// Reset behaviour is probed mid-cycle to confirm it acts without a clock edge.
module tb_demux_1to4;
    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    demux_1to4_if #(.DW(1)) b4 ();
    demux_1to4_if #(.DW(1)) b2 ();
    demux_1to4_if #(.DW(1)) b3 ();
    demux_1to4_if #(.DW(8)) b8 ();

    demux_1to4 #(.DW(1), .N_OUT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
    demux_1to4 #(.DW(1), .N_OUT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
    demux_1to4 #(.DW(1), .N_OUT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
    demux_1to4 #(.DW(8), .N_OUT(4)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

    // Outputs packed as {Out4,Out3,Out2,Out1} in the low nibble.
    logic [7:0] o4, o2, o3, e4, e2, e3, e8;
    assign o4 = {4'd0, b4.Out4, b4.Out3, b4.Out2, b4.Out1};
    assign o2 = {4'd0, b2.Out4, b2.Out3, b2.Out2, b2.Out1};
    assign o3 = {4'd0, b3.Out4, b3.Out3, b3.Out2, b3.Out1};
    assign e4 = {7'd0, b4.err};
    assign e2 = {7'd0, b2.err};
    assign e3 = {7'd0, b3.err};
    assign e8 = {7'd0, b8.err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        b4.Sel = 2'd0; b4.E = 1'b0;
        b2.Sel = 2'd0; b2.E = 1'b0;
        b3.Sel = 2'd0; b3.E = 1'b0;
        b8.Sel = 2'd0; b8.E = 8'h00;

        // Reset asserted before any clock edge must already clear everything.
        #1 rst = 1'b1;
        #1;
        check("rst_o4", o4, 8'h00);
        check("rst_e4", e4, 8'h00);
        check("rst_o2", o2, 8'h00);
        check("rst_e2", e2, 8'h00);
        check("rst_o8_3", b8.Out3, 8'h00);
`ifdef DEMUX_1TO4_ERRCNT_EN
        check("rst_cnt", b2.err_cnt, 8'h00);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Scenario 1: one-hot walk with E=1.
        b4.E = 1'b1;
        for (int s = 0; s < 4; s++) begin
            b4.Sel = 2'(s);
            tick();
            check($sformatf("walk_o_%0d", s), o4, 8'(1 << s));
            check($sformatf("walk_e_%0d", s), e4, 8'h00);
        end

        // Scenario 2: E=0 sweep gives all-zero, no error.
        b4.E = 1'b0;
        for (int s = 0; s < 4; s++) begin
            b4.Sel = 2'(s);
            tick();
            check($sformatf("zero_o_%0d", s), o4, 8'h00);
            check($sformatf("zero_e_%0d", s), e4, 8'h00);
        end

        // Scenario 3: N_OUT=2, valid then invalid selects.
        b2.E = 1'b1;
        b2.Sel = 2'd0; tick(); check("n2_s0_o", o2, 8'h01); check("n2_s0_e", e2, 8'h00);
        b2.Sel = 2'd1; tick(); check("n2_s1_o", o2, 8'h02); check("n2_s1_e", e2, 8'h00);
        b2.Sel = 2'd2; tick(); check("n2_s2_o", o2, 8'h00); check("n2_s2_e", e2, 8'h01);
        b2.Sel = 2'd3; tick(); check("n2_s3_o", o2, 8'h00); check("n2_s3_e", e2, 8'h01);
`ifdef DEMUX_1TO4_ERRCNT_EN
        check("n2_cnt2", b2.err_cnt, 8'd2);
`endif
        b2.Sel = 2'd1; tick(); check("n2_back_o", o2, 8'h02); check("n2_back_e", e2, 8'h00);
`ifdef DEMUX_1TO4_ERRCNT_EN
        check("n2_cnt_hold", b2.err_cnt, 8'd2);
`endif
        b2.E = 1'b0; b2.Sel = 2'd0;

        // N_OUT=3: top valid port and the tied-off Out4.
        b3.E = 1'b1;
        b3.Sel = 2'd2; tick(); check("n3_s2_o", o3, 8'h04); check("n3_s2_e", e3, 8'h00);
        b3.Sel = 2'd3; tick(); check("n3_s3_o", o3, 8'h00); check("n3_s3_e", e3, 8'h01);
        b3.E = 1'b0; b3.Sel = 2'd0;

        // Scenario 4: DW=8 full-width routing.
        b8.E = 8'hA5; b8.Sel = 2'd2;
        tick();
        check("w8_out3", b8.Out3, 8'hA5);
        check("w8_out1", b8.Out1, 8'h00);
        check("w8_out2", b8.Out2, 8'h00);
        check("w8_out4", b8.Out4, 8'h00);
        check("w8_err", e8, 8'h00);
        b8.E = 8'h5A; b8.Sel = 2'd3;
        tick();
        check("w8_out4b", b8.Out4, 8'h5A);
        check("w8_out3b", b8.Out3, 8'h00);

        // Scenario 5: steady select, then async reset mid-cycle.
        b4.E = 1'b1; b4.Sel = 2'd1;
        tick(); check("hold1_o", o4, 8'h02);
        tick(); check("hold2_o", o4, 8'h02);
        #2 rst = 1'b1;
        #1;
        check("arst_o4", o4, 8'h00);
        check("arst_o8", b8.Out4, 8'h00);
`ifdef DEMUX_1TO4_ERRCNT_EN
        check("arst_cnt", b2.err_cnt, 8'h00);
`endif
        rst = 1'b0;
        #1;
        check("post_rel_o4", o4, 8'h00);
        tick();
        check("post_rel_edge_o4", o4, 8'h02);
        check("post_rel_edge_e4", e4, 8'h00);

`ifdef DEMUX_1TO4_ERRCNT_EN
        // Scenario 6: saturation after 300 invalid cycles (counter cleared by the reset above).
        b2.Sel = 2'd3;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) check("sat_254", b2.err_cnt, 8'd254);
            if (i == 255) check("sat_255", b2.err_cnt, 8'd255);
        end
        check("sat_300", b2.err_cnt, 8'd255);
        check("sat_err", e2, 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/demux_1to4.md
DEMUX_1TO4 -- requirements
Module: demux_1to4

Interface
REQ-001 The block SHALL provide parameter DW, default 1, meaning width of data input E and of each output.
REQ-002 The block SHALL provide parameter N_OUT, default 4, legal range 2..4, meaning number of active output ports.
REQ-003 The block SHALL provide port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 The block SHALL provide port Sel, input, 2 bits, output select.
REQ-006 The block SHALL provide port E, input, DW bits, data/enable to route.
REQ-007 The block SHALL provide ports Out4, Out3, Out2, Out1, each output, DW bits, routed outputs.
REQ-008 The block SHALL provide port err, output, 1 bit, invalid-select flag.
REQ-009 The block SHALL provide port err_cnt, output, 8 bits, invalid-select count; present only under the REQ-024 macro.

Function
REQ-010 The block SHALL decode Sel as follows: 0 -> Out1, 1 -> Out2, 2 -> Out3, 3 -> Out4.
REQ-011 The block SHALL treat Sel as valid when Sel < N_OUT and as invalid otherwise.
REQ-012 On every rising clk edge with valid Sel, the selected output SHALL load E and every other output SHALL load 0.
REQ-013 On every rising clk edge with invalid Sel, all outputs SHALL load 0 and err SHALL load 1.
REQ-014 On every rising clk edge with valid Sel, err SHALL load 0.
REQ-015 Latency SHALL be exactly one clk cycle from Sel/E sampling to Out*/err; there is no handshake and every cycle is independent.
REQ-016 Output ports with index > N_OUT SHALL be tied permanently to 0.
REQ-017 When E = 0 with valid Sel, all outputs SHALL be 0 after the edge; err SHALL be 0.
REQ-018 With DW > 1, the selected output SHALL equal E bit-for-bit, with no masking or truncation.
REQ-019 Sel or E values held across multiple cycles SHALL yield stable outputs, with no glitch between consecutive identical inputs.

Reset
REQ-020 While rst = 1, Out1..Out4, err and err_cnt (when present) SHALL be 0, immediately and independent of clk.
REQ-021 Asserting rst mid-operation SHALL clear all outputs within the same cycle; pending sampled data SHALL be discarded.
REQ-022 After rst deasserts, the first rising clk edge SHALL sample Sel/E normally.
REQ-023 The reset value of every output, including err_cnt, SHALL be 0.

Configuration
REQ-024 With macro DEMUX_1TO4_ERRCNT_EN defined, the block SHALL include port err_cnt, incremented by 1 on each rising edge with invalid Sel, saturating at 255.
REQ-025 Without DEMUX_1TO4_ERRCNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Scenario 1: N_OUT=4, DW=1, E=1, Sel=0,1,2,3 on successive cycles -> one cycle later Out1..Out4 each one-hot in turn (0001, 0010, 0100, 1000 as Out4..Out1), err=0.
REQ-027 Scenario 2: N_OUT=4, E=0, Sel sweeps 0..3 -> all outputs 0, err=0.
REQ-028 Scenario 3: N_OUT=2, E=1, Sel=2 then 3 -> all outputs 0, err=1 on both cycles; with macro defined, err_cnt=2.
REQ-029 Scenario 4: DW=8, E=8'hA5, Sel=2 -> Out3=8'hA5, Out1=Out2=Out4=0 after one edge.
REQ-030 Scenario 5: E=1, Sel=1 steady, assert rst between clock edges -> Out2 drops to 0 immediately; after release plus one edge, Out2=1.
REQ-031 Scenario 6: macro defined, N_OUT=2, invalid Sel held for 300 cycles -> err_cnt saturates at 255 and holds.
